// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//
// Oversampling asynchronous serial receiver for the host-side end of the
// camera Txd stream. Frames are 8N1 by default: one start bit, eight data bits
// LSB-first, and one stop bit. Each received byte is held in a one-entry
// register with a level valid / ack handshake.
//
// Build option:
//   UART_RX_PARITY_EN  - when defined, frames are 8E1. An even-parity bit
//                        follows the data bits. A mismatch pulses parity_err
//                        and the byte is discarded. When undefined, there is
//                        no parity state and parity_err is tied low.
//
// Parameters:
//   CLK_FREQ  - SYS_CLK frequency in Hz
//   BAUD      - line rate in bit/s. BIT_CNT = CLK_FREQ/BAUD, HALF = BIT_CNT/2
//
// Ports:
//   SYS_CLK     in   system clock; all logic on the rising edge
//   RST_N       in   asynchronous active-low reset
//   Rxd         in   serial line, idle high, asynchronous to SYS_CLK
//   rx_data     out  [7:0] held received byte
//   rx_valid    out  high while rx_data holds an unconsumed byte
//   rx_ack      in   consumer accepts rx_data (only honoured while rx_valid=1)
//   rx_busy     out  high while a frame is being received
//   frame_err   out  one-cycle pulse: stop bit sampled low
//   overrun     out  one-cycle pulse: byte completed while the holding
//                    register was still full
//   parity_err  out  one-cycle pulse: parity mismatch (parity build only)
// ---------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       Rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int TW      = $clog2(BIT_CNT) + 1;

  // Terminal counts of the bit timer. The timer wraps to zero at each sample.
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CNT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  // Even parity of a data byte: the XOR of all eight bits.
  function automatic logic f_parity(input logic [7:0] d);
    return ^d;
  endfunction

  // Input synchronizer plus one history flop for edge detection.
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_rxs;
  logic w_fall;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_busy;
  logic          r_ferr;
  logic          r_ovr;
`ifdef UART_RX_PARITY_EN
  logic          r_perr;
  logic          r_par_bad;
`endif

  assign w_rxs  = r_sync2;
  // A start needs a genuine 1->0 transition, so a line stuck low never retriggers.
  assign w_fall = r_prev & ~w_rxs;

  // Bring Rxd into the SYS_CLK domain and keep one cycle of history.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= Rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Frame FSM, bit timer, shift register, holding register and status pulses.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_idx     <= 3'd0;
      r_shift   <= 8'd0;
      r_data    <= 8'd0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      // Status outputs are single-cycle pulses unless set below.
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif

      // Consumer handshake. A commit later in this block overrides the clear,
      // which lets a new byte load in the same cycle the old one is taken.
      if (r_valid && rx_ack) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end

      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_fall) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        // Re-check the start bit at its centre to reject short glitches.
        S_START: begin
          if (r_timer == HALF_LAST) begin
            r_timer <= '0;
            if (w_rxs) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_idx   <= 3'd0;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        // Sampling is now aligned to bit centres; shift in LSB-first.
        S_DATA: begin
          if (r_timer == BIT_LAST) begin
            r_timer <= '0;
            r_shift <= {w_rxs, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        // The verdict is kept until the stop bit, where a framing error takes precedence.
        S_PARITY: begin
          if (r_timer == BIT_LAST) begin
            r_timer   <= '0;
            r_par_bad <= (w_rxs != f_parity(r_shift));
            r_state   <= S_STOP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
`endif

        S_STOP: begin
          if (r_timer == BIT_LAST) begin
            r_timer <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!w_rxs) begin
              r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (r_par_bad) begin
              r_perr <= 1'b1;
`endif
            end else if (!r_valid || rx_ack) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              // Holding register still full: keep the old byte, drop the new one.
              r_ovr <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_busy   = r_busy;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Asynchronous serial receiver, 8N1: the receiving end of the Txd stream produced by the OV7670 image-over-UART path.
- Oversamples Rxd on SYS_CLK, recovers bytes LSB-first, and holds each byte in a one-entry register with a valid/ack handshake.
- Used for host-side loopback checking of the camera stream and for a future host command channel into the SCCB configuration logic.

Parameters:
CLK_FREQ, 50_000_000, SYS_CLK frequency in Hz
BAUD, 115200, line rate in bit/s; BIT_CNT = CLK_FREQ/BAUD (integer division), HALF = BIT_CNT/2

Ports:
SYS_CLK  input  1  system clock, all logic on rising edge
RST_N  input  1  asynchronous active-low reset
Rxd  input  1  serial line, idle high, asynchronous to SYS_CLK
rx_data  output  8  held received byte
rx_valid  output  1  level; high while rx_data holds an unconsumed byte
rx_ack  input  1  consumer accepts rx_data; sampled only while rx_valid=1
rx_busy  output  1  high in any state other than IDLE
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while holding register full
parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Clock/reset: one clock, SYS_CLK. RST_N is asynchronous, active-low; the block is reset whenever RST_N=0.
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, parity_err=0, state=IDLE, all counters=0, synchronizer flops=1.
- Input path: 2-FF synchronizer on Rxd, plus one extra flop for edge detection. Every decision uses the synchronized value rxs.
- IDLE: on an rxs 1->0 transition -> START, bit timer cleared. A line held low never retriggers; a fresh 1->0 edge is required.
- START: when the timer reaches HALF-1, sample rxs.
  - rxs=1 -> IDLE (glitch rejected, no flags).
  - rxs=0 -> DATA; timer cleared, bit index = 0.
- DATA: sample every BIT_CNT cycles, i.e. at bit centres. Shift into the shift register LSB-first. After bit index 7 -> STOP (or PARITY when the feature is enabled).
- STOP: sample after BIT_CNT cycles.
  - rxs=1: commit the byte, then -> IDLE.
  - rxs=0: frame_err pulses, byte discarded, -> IDLE.
- Commit rules (in the cycle after the stop sample):
  - rx_valid=0: rx_data <= byte, rx_valid <= 1.
  - rx_valid=1 and rx_ack=1 in the same cycle: new byte loads, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ack=0: rx_data keeps the old byte, new byte dropped, overrun pulses.
- Handshake: rx_ack=1 while rx_valid=1 clears rx_valid on the next edge. rx_ack while rx_valid=0 is ignored.
- Latency: rx_valid rises 1 cycle after the stop-bit sample. The stop-bit sample is ~2 synchronizer cycles after the true mid-stop point on the pin.
- Counters: bit timer is $clog2(BIT_CNT)+1 bits and wraps to 0 at each sample. Bit index is 3 bits.
- rx_busy=1 in START/DATA/PARITY/STOP.
- Back-to-back frames: after a committing STOP, IDLE catches a start edge immediately. This gives ~half-bit margin; no extra gap is required.
- Reset mid-frame: all state clears immediately; a partial byte is lost. After release, the block waits for a new 1->0 edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. State PARITY follows DATA and samples one bit after BIT_CNT cycles.
  - If the parity bit != XOR of the 8 data bits: parity_err pulses in the cycle after the stop sample, and the byte is not committed.
  - frame_err takes precedence when both occur; only frame_err pulses.
- Undefined: no PARITY state; parity_err is tied 0.

Test Plan:
- All scenarios use CLK_FREQ=20_000_000, BAUD=1_000_000 (BIT_CNT=20, 50 ns clock).
- Send 0xA5 (8N1), rx_ack held 0 -> rx_valid=1, rx_data=0xA5, frame_err=0; pulse rx_ack -> rx_valid=0 next cycle.
- Send 0x00, 0xFF, 0x3C back-to-back, acking each within 5 cycles of rx_valid -> three commits in order, no flags.
- Send 0x11 then 0x22, no ack -> rx_data stays 0x11, rx_valid=1, one overrun pulse at 0x22 completion. Repeat with rx_ack asserted exactly in the 0x22 commit cycle -> rx_data=0x22, no overrun.
- Send 0x55 with stop bit forced low -> frame_err one pulse, rx_valid stays 0. Line held low 100 cycles, then high, then a clean 0x66 -> only 0x66 received.
- Low glitch of 5 cycles on an idle line -> returns to IDLE, no rx_valid, no flags. Also assert RST_N low for 3 cycles after bit 3 of a frame -> all outputs 0; the next full frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> committed; the same byte with parity bit 0 -> parity_err pulse, rx_valid stays 0.
